uart_tx_cfg: RTL and testbench

Parametrised UART transmitter for the photo-frame serial path, superseding the fixed 8N1 transmitter. It accepts words over a valid/ready handshake into an internal FIFO and serialises them LSB-first. Data width, parity and stop bits are set per instance. Back-to-back frames are sent with no idle gap. It sits between the frame-buffer/command logic and the board TX pin.

---
 rtl/uart_tx_cfg_if.sv | 26 ++
 rtl/uart_tx_cfg.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_cfg_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_cfg_if
//  Brief    : Word handshake between a data source and the UART transmitter.
//  Revision : 1.0
// ============================================================================
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] i_data_tx;
    logic                 i_data_valid;
    logic                 o_data_ready;

    modport master (
        output i_data_tx,
        output i_data_valid,
        input  o_data_ready
    );

    modport slave (
        input  i_data_tx,
        input  i_data_valid,
        output o_data_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_cfg
//  Brief    : Parametrised FIFO-fed UART transmitter, LSB first, no idle gap
//             between queued frames.
//  Revision : 1.0
// ============================================================================
module uart_tx_cfg #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk_sys,
    input  logic                          i_rst,
    uart_tx_cfg_if.slave                  bus,
    output logic                          o_uart_tx,
    output logic                          o_busy,
    output logic [2:0]                    o_state,
    output logic                          o_baud_pulse,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
    localparam int C_DIV   = CLK_FREQ / BAUD_RATE;
    localparam int C_CNT_W = (C_DIV > 2) ? $clog2(C_DIV) : 1;
    localparam int C_PTR_W = $clog2(FIFO_DEPTH);
    localparam int C_LVL_W = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX   = C_CNT_W'(C_DIV - 1);
    localparam logic [3:0]         C_IDX_LAST  = 4'(DATA_BITS - 1);
    localparam logic               C_STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [C_LVL_W-1:0] C_FULL      = C_LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [C_CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   stop_q, stop_d;
    logic [C_PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [C_LVL_W-1:0]     level_q, level_d;
    logic                   ready_q, ready_d;
    logic                   tx_q, tx_d;
    logic                   pulse_q, pulse_d;
    logic                   busy_q, busy_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

    logic                   w_push, w_pop, w_tick, w_nempty;
    logic [DATA_BITS-1:0]   w_head;

    assign w_push   = bus.i_data_valid && ready_q;
    assign w_nempty = (level_q != '0);
    assign w_head   = mem_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        stop_d  = stop_q;
        w_pop   = 1'b0;
        w_tick  = (state_q != S_IDLE) && (cnt_q == C_CNT_MAX);

        case (state_q)
            S_IDLE:   w_pop = w_nempty;
            S_START:  if (w_tick) state_d = S_DATA;
            S_DATA: begin
                if (w_tick) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == C_IDX_LAST)
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (w_tick) state_d = S_STOP;
            S_STOP: begin
                if (w_tick) begin
                    if (stop_q == C_STOP_LAST) begin
                        w_pop = w_nempty;
                        if (!w_nempty) state_d = S_IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default:  state_d = S_IDLE;
        endcase

        // Parity is fixed at load time from the whole word, before shifting.
        if (w_pop) begin
            state_d = S_START;
            shift_d = w_head;
            par_d   = (PARITY == 2) ? ^w_head : ~^w_head;
            idx_d   = 4'd0;
            stop_d  = 1'b0;
        end

        cnt_d = (state_q == S_IDLE || w_tick) ? '0 : cnt_q + C_CNT_W'(1);

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        pulse_d = (state_d != S_IDLE) && (cnt_d == C_CNT_MAX);

        wr_ptr_d = w_push ? wr_ptr_q + C_PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + C_PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        if (w_push && !w_pop)
            level_d = level_q + C_LVL_W'(1);
        else if (!w_push && w_pop)
            level_d = level_q - C_LVL_W'(1);
        ready_d = (level_d != C_FULL);
        busy_d  = (state_d != S_IDLE) || (level_d != '0);
    end

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            stop_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
            tx_q     <= 1'b1;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            stop_q   <= stop_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
            tx_q     <= tx_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge i_clk_sys) begin
        if (w_push) mem_q[wr_ptr_q] <= bus.i_data_tx;
    end

    assign bus.o_data_ready = ready_q;
    assign o_uart_tx        = tx_q;
    assign o_busy           = busy_q;
    assign o_state          = state_q;
    assign o_baud_pulse     = pulse_q;
    assign o_fifo_level     = level_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_cfg
//  Brief    : Four transmitter configurations against a frame-level model.
//  Revision : 1.0
// ============================================================================
module tb_uart_tx_cfg;
    localparam int NI    = 4;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic       line;
        logic [2:0] st;
        logic       pulse;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [NI-1:0]       vld = '0;
    logic [NI-1:0][8:0]  dat = '0;
    logic [NI-1:0]       tx_o, busy_o, pulse_o, rdy_o;
    logic [NI-1:0][2:0]  st_o, lvl_o;

    task automatic check(input string name, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s inst%0d: got %0d, want %0d (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    // Line level of every bit of a frame, index 0 = start bit; unused bits stay high.
    function automatic logic [15:0] frame_bits(input logic [8:0] w, input int db, input int par);
        logic [15:0] b;
        logic        p;
        b    = '1;
        p    = 1'b0;
        b[0] = 1'b0;
        for (int i = 0; i < db; i++) begin
            b[1+i] = w[i];
            p      = p ^ w[i];
        end
        if (par != 0) b[1+db] = (par == 2) ? p : ~p;
        return b;
    endfunction

    function automatic logic [2:0] st_of(input int b, input int db, input int par);
        if (b == 0) return 3'd1;
        if (b <= db) return 3'd2;
        if (b == db + 1 && par != 0) return 3'd3;
        return 3'd4;
    endfunction

    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int DB  = (k == 3) ? 5 : 8;
        localparam int PAR = (k == 1) ? 2 : ((k == 2) ? 1 : 0);
        localparam int STP = (k == 1) ? 2 : 1;

        uart_tx_cfg_if #(.DATA_BITS(DB)) bus ();
        assign bus.i_data_valid = vld[k];
        assign bus.i_data_tx    = dat[k][DB-1:0];
        assign rdy_o[k]         = bus.o_data_ready;

        uart_tx_cfg #(
            .CLK_FREQ(40), .BAUD_RATE(10), .DATA_BITS(DB),
            .PARITY(PAR), .STOP_BITS(STP), .FIFO_DEPTH(DEPTH)
        ) dut (
            .i_clk_sys    (clk),
            .i_rst        (rst),
            .bus          (bus),
            .o_uart_tx    (tx_o[k]),
            .o_busy       (busy_o[k]),
            .o_state      (st_o[k]),
            .o_baud_pulse (pulse_o[k]),
            .o_fifo_level (lvl_o[k])
        );

        // Model: FIFO of words plus the per-clock expansion of the frame on the wire.
        logic [8:0]  mq [$];
        rec_t        sched [$];
        rec_t        cur, r;
        logic        rdy_m, do_pop, do_push;
        logic [8:0]  w_in, w_out;
        logic [15:0] fb;
        int          nb;

        always @(negedge clk) begin
            if (rst) begin
                mq.delete();
                sched.delete();
                cur   = rec_t'{line: 1'b1, st: 3'd0, pulse: 1'b0};
                rdy_m = 1'b0;
            end
            check("tx",    k, int'(tx_o[k]),    int'(cur.line));
            check("state", k, int'(st_o[k]),    int'(cur.st));
            check("pulse", k, int'(pulse_o[k]), int'(cur.pulse));
            check("level", k, int'(lvl_o[k]),   mq.size());
            check("busy",  k, int'(busy_o[k]),  int'((cur.st != 3'd0) || (mq.size() != 0)));
            check("ready", k, int'(rdy_o[k]),   int'(rdy_m));
            if (!rst) begin
                do_push = vld[k] && rdy_m;
                w_in    = dat[k] & 9'((1 << DB) - 1);
                do_pop  = (mq.size() != 0) && (sched.size() == 0);
                if (do_pop) begin
                    w_out = mq.pop_front();
                    fb    = frame_bits(w_out, DB, PAR);
                    nb    = 1 + DB + ((PAR != 0) ? 1 : 0) + STP;
                    for (int b = 0; b < nb; b++) begin
                        for (int c = 0; c < DIV; c++) begin
                            r.line  = fb[b];
                            r.st    = st_of(b, DB, PAR);
                            r.pulse = (c == DIV - 1);
                            sched.push_back(r);
                        end
                    end
                end
                if (sched.size() != 0) cur = sched.pop_front();
                else cur = rec_t'{line: 1'b1, st: 3'd0, pulse: 1'b0};
                if (do_push) mq.push_back(w_in);
                rdy_m = (mq.size() < DEPTH);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step();
    endtask

    task automatic push_word(input int k, input logic [8:0] w, output int at);
        int   n;
        logic rd;
        n      = 0;
        at     = -1;
        vld[k] = 1'b1;
        dat[k] = w;
        while (at < 0 && n < 400) begin
            rd = rdy_o[k];
            step();
            n++;
            if (rd) at = cyc;
        end
        vld[k] = 1'b0;
        total++;
        if (at < 0) begin
            bad++;
            $display("FAIL push_accept inst%0d: not accepted after %0d cycles, want acceptance", k, n);
        end
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while ((st_o[k] != 3'd0 || lvl_o[k] != 3'd0) && n < 1000) begin
            step();
            n++;
        end
        total++;
        if (n >= 1000) begin
            bad++;
            $display("FAIL drain inst%0d: still busy after %0d cycles, want idle", k, n);
        end
    endtask

    // Push one word to an idle, empty instance and sample each bit mid-period.
    task automatic frame_probe(input int k, input logic [8:0] w, input int nbits,
                               output logic [11:0] seq, output int flen);
        int n0, n;
        seq = '1;
        n   = 0;
        push_word(k, w, n0);
        check("push_edge_tx", k, int'(tx_o[k]), 1);
        check("push_edge_level", k, int'(lvl_o[k]), 1);
        step();
        check("start_tx", k, int'(tx_o[k]), 0);
        check("start_state", k, int'(st_o[k]), 1);
        for (int i = 0; i < nbits; i++) begin
            wait_cyc(n0 + 2 + DIV * i);
            seq[i] = tx_o[k];
        end
        while (st_o[k] != 3'd0 && n < 200) begin
            step();
            n++;
        end
        flen = cyc - (n0 + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] seq;
        int fl, at, a, n0, maxlvl, t0;
        logic full_seen, started;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_tx",    0, int'(tx_o[0]),    1);
        check("rst_state", 0, int'(st_o[0]),    0);
        check("rst_pulse", 0, int'(pulse_o[0]), 0);
        check("rst_busy",  0, int'(busy_o[0]),  0);
        check("rst_level", 0, int'(lvl_o[0]),   0);
        step();
        for (int k = 0; k < NI; k++) check("ready_after_rst", k, int'(rdy_o[k]), 1);

        // 8N1, 0x5A
        frame_probe(0, 9'h05A, 10, seq, fl);
        check("seq_5a_8n1", 0, int'(seq[9:0]), 'h2B4);
        check("len_8n1", 0, fl, 40);

        // even parity, two stop bits
        frame_probe(1, 9'h05A, 12, seq, fl);
        check("seq_5a_8e2", 1, int'(seq), 'hCB4);
        check("par_even_5a", 1, int'(seq[9]), 0);
        check("stop2", 1, int'(seq[11:10]), 3);
        check("len_8e2", 1, fl, 48);

        frame_probe(2, 9'h05A, 11, seq, fl);
        check("par_odd_5a", 2, int'(seq[9]), 1);
        check("len_8o1", 2, fl, 44);

        frame_probe(1, 9'h007, 12, seq, fl);
        check("par_even_07", 1, int'(seq[9]), 1);
        frame_probe(2, 9'h007, 11, seq, fl);
        check("par_odd_07", 2, int'(seq[9]), 0);

        // 5 data bits; the upper source bits must not reach the line
        frame_probe(3, 9'h0FF, 7, seq, fl);
        check("seq_5n1", 3, int'(seq[6:0]), 'h7E);
        check("len_5n1", 3, fl, 28);

        // Six words held back-to-back into a depth-4 FIFO
        maxlvl = 0; full_seen = 1'b0; started = 1'b0; t0 = 0;
        fork
            begin
                for (int i = 1; i <= 6; i++) push_word(0, 9'(i), at);
            end
            begin
                for (int n = 0; n < 700 && !(started && st_o[0] == 3'd0); n++) begin
                    step();
                    if (int'(lvl_o[0]) > maxlvl) maxlvl = int'(lvl_o[0]);
                    if (lvl_o[0] == 3'd4 && !rdy_o[0]) full_seen = 1'b1;
                    if (!started && st_o[0] != 3'd0) begin
                        started = 1'b1;
                        t0      = cyc;
                    end
                end
            end
        join
        check("max_level", 0, maxlvl, 4);
        check("ready_low_when_full", 0, int'(full_seen), 1);
        check("six_frame_span", 0, cyc - t0, 240);

        // Push coinciding with the frame-end pop at level 2
        push_word(0, 9'h011, a);
        push_word(0, 9'h022, at);
        push_word(0, 9'h033, at);
        wait_cyc(a + 40);
        check("level_before_swap", 0, int'(lvl_o[0]), 2);
        push_word(0, 9'h044, at);
        check("swap_edge", 0, at, a + 41);
        check("level_after_swap", 0, int'(lvl_o[0]), 2);
        check("state_after_swap", 0, int'(st_o[0]), 1);
        wait_idle(0);

        // Asynchronous reset in the middle of data bit 3
        push_word(0, 9'h0A5, n0);
        push_word(0, 9'h03C, at);
        wait_cyc(n0 + 18);
        check("pre_rst_state", 0, int'(st_o[0]), 2);
        check("pre_rst_tx", 0, int'(tx_o[0]), 0);
        check("pre_rst_level", 0, int'(lvl_o[0]), 1);
        rst = 1'b1;
        #1;
        check("async_rst_tx", 0, int'(tx_o[0]), 1);
        check("async_rst_state", 0, int'(st_o[0]), 0);
        check("async_rst_level", 0, int'(lvl_o[0]), 0);
        step();
        step();
        rst = 1'b0;
        frame_probe(0, 9'h05A, 10, seq, fl);
        check("seq_after_rst", 0, int'(seq[9:0]), 'h2B4);
        check("len_after_rst", 0, fl, 40);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
